// File: rtl/axis_traffic_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_traffic_gen_pkg : shared types, LFSR constants and step function |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package axis_traffic_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] LFSR_SEED = 32'hFFFFFFFF;

  // Galois right-shift step
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_traffic_gen_keep.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_traffic_gen_keep : beats per packet and last-beat byte enables  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module axis_traffic_gen_keep #(
  parameter int BYTES     = 8,
  parameter int LEN_WIDTH = 16
) (
  input  logic [LEN_WIDTH-1:0] i_len,
  output logic [LEN_WIDTH-1:0] o_beats,
  output logic [BYTES-1:0]     o_last_keep
);

  logic [LEN_WIDTH-1:0] w_rem;

  // Divide-and-test avoids the overflow of (len + BYTES - 1) near the top of the range
  always_comb begin
    w_rem   = i_len % LEN_WIDTH'(BYTES);
    o_beats = (i_len / LEN_WIDTH'(BYTES)) + ((w_rem != '0) ? LEN_WIDTH'(1) : LEN_WIDTH'(0));
    for (int i = 0; i < BYTES; i++) begin
      o_last_keep[i] = (w_rem == '0) || (LEN_WIDTH'(i) < w_rem);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_traffic_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_traffic_gen : AXI4-Stream fixed-length packet generator        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module axis_traffic_gen
  import axis_traffic_gen_pkg::*;
#(
  parameter int DWIDTH    = 64,
  parameter int LEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [31:0]           cfg_pkt_num,
  input  logic [7:0]            cfg_gap,
  input  logic                  cfg_mode,
  output logic [DWIDTH-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DWIDTH/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [63:0]           sent_pkt_cnt
);

  localparam int BYTES = DWIDTH / 8;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_idx_q, beat_idx_d;
  logic [31:0]          num_q, num_d;
  logic [31:0]          word_q, word_d;
  logic [7:0]           gap_q, gap_d;
  logic [7:0]           gap_cnt_q, gap_cnt_d;
  logic                 mode_q, mode_d;
  logic                 stop_q, stop_d;
  logic                 done_q, done_d;
  logic [63:0]          sent_q, sent_d;

  logic [LEN_WIDTH-1:0] w_beats;
  logic [BYTES-1:0]     w_last_keep;
  logic [BYTES-1:0]     w_keep;
  logic                 w_last;
  logic                 w_hs;

  axis_traffic_gen_keep #(
    .BYTES     (BYTES),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_keep (
    .i_len       (len_q),
    .o_beats     (w_beats),
    .o_last_keep (w_last_keep)
  );

  assign m_axis_tvalid = (state_q == SEND);
  assign w_hs          = m_axis_tvalid & m_axis_tready;
  assign w_last        = (beat_idx_q == w_beats - LEN_WIDTH'(1));
  assign m_axis_tlast  = w_last;
  assign m_axis_tkeep  = w_keep;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign sent_pkt_cnt  = sent_q;

  // Payload is a function of registers only, so it is inherently stable during stalls
  always_comb begin
    w_keep = w_last ? w_last_keep : '1;
    for (int j = 0; j < BYTES; j++) begin
      m_axis_tdata[8*j +: 8] = w_keep[j] ? word_q[8*(j%4) +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    num_d      = num_q;
    gap_d      = gap_q;
    mode_d     = mode_q;
    beat_idx_d = beat_idx_q;
    word_d     = word_q;
    gap_cnt_d  = gap_cnt_q;
    stop_d     = stop_q;
    sent_d     = sent_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_stop) begin
          len_d      = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
          num_d      = cfg_pkt_num;
          gap_d      = cfg_gap;
          mode_d     = cfg_mode;
          beat_idx_d = '0;
          word_d     = cfg_mode ? LFSR_SEED : 32'h0;
          stop_d     = 1'b0;
          sent_d     = 64'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (cfg_stop) stop_d = 1'b1;
        if (w_hs) begin
          word_d     = mode_q ? lfsr_next(word_q) : word_q + 32'd1;
          beat_idx_d = beat_idx_q + LEN_WIDTH'(1);
          if (w_last) begin
            beat_idx_d = '0;
            sent_d     = sent_q + 64'd1;
            if (stop_q || cfg_stop || ((num_q != '0) && (sent_d == {32'd0, num_q}))) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q - 8'd1;
            end
          end
        end
      end
      GAP: begin
        if (cfg_stop) stop_d = 1'b1;
        if (gap_cnt_q == '0) begin
          if (stop_q || cfg_stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SEND;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      num_q      <= '0;
      gap_q      <= '0;
      mode_q     <= 1'b0;
      beat_idx_q <= '0;
      word_q     <= '0;
      gap_cnt_q  <= '0;
      stop_q     <= 1'b0;
      sent_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      num_q      <= num_d;
      gap_q      <= gap_d;
      mode_q     <= mode_d;
      beat_idx_q <= beat_idx_d;
      word_q     <= word_d;
      gap_cnt_q  <= gap_cnt_d;
      stop_q     <= stop_d;
      sent_q     <= sent_d;
      done_q     <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_traffic_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axis_traffic_gen : scoreboard bench for axis_traffic_gen         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_axis_traffic_gen;

  localparam int BY = 8;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_mode = 1'b0;
  logic [15:0] cfg_pkt_len = '0;
  logic [31:0] cfg_pkt_num = '0;
  logic [7:0]  cfg_gap = '0;
  logic [63:0] tdata;
  logic        tvalid, tlast, busy, done;
  logic        tready = 1'b1;
  logic [7:0]  tkeep;
  logic [63:0] sent;

  int checks = 0, errors = 0;
  beat_t       exp_q[$];
  logic [63:0] cap_data[$];
  logic [7:0]  cap_keep[$];
  logic sb_en = 1'b1, rnd_ready = 1'b0, prev_last_hs = 1'b0;
  int   hs_cnt = 0, low_cnt = 0;

  always #5 clk = ~clk;

  axis_traffic_gen #(.DWIDTH(64), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_num(cfg_pkt_num), .cfg_gap(cfg_gap),
    .cfg_mode(cfg_mode), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .busy(busy), .done(done), .sent_pkt_cnt(sent)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_lfsr(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  task automatic push_exp(input int len, input int npk, input bit mode);
    int l, nb, rem;
    logic [31:0] w;
    beat_t e;
    l   = (len == 0) ? 1 : len;
    nb  = (l + BY - 1) / BY;
    rem = l % BY;
    w   = mode ? 32'hFFFFFFFF : 32'h0;
    for (int p = 0; p < npk; p++) begin
      for (int b = 0; b < nb; b++) begin
        e.last = (b == nb - 1);
        e.keep = 8'hFF;
        if (e.last && rem != 0) e.keep = 8'((1 << rem) - 1);
        for (int j = 0; j < BY; j++) e.data[8*j +: 8] = e.keep[j] ? w[8*(j%4) +: 8] : 8'h00;
        exp_q.push_back(e);
        w = mode ? m_lfsr(w) : w + 32'd1;
      end
    end
  endtask

  // Drives tready just after each rising edge
  initial begin
    forever begin
      @(posedge clk); #1;
      tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, stall stability and idle-cycle counting
  initial begin
    beat_t e;
    logic prev_stall;
    logic [63:0] pd;
    logic [7:0] pk;
    logic pl;
    prev_stall = 1'b0; pd = '0; pk = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_en) begin
        if (prev_stall) begin
          chk("stall_valid", 64'(tvalid), 64'd1);
          chk("stall_data", tdata, pd);
          chk("stall_keep", 64'(tkeep), 64'(pk));
          chk("stall_last", 64'(tlast), 64'(pl));
        end
        if (tvalid && tready) begin
          hs_cnt++;
          cap_data.push_back(tdata);
          cap_keep.push_back(tkeep);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data 0x%0h, required no beat", tdata);
          end else begin
            e = exp_q.pop_front();
            chk("sb_data", tdata, e.data);
            chk("sb_keep", 64'(tkeep), 64'(e.keep));
            chk("sb_last", 64'(tlast), 64'(e.last));
          end
        end
        if (busy && !tvalid) low_cnt++;
      end
      prev_stall   = tvalid && !tready;
      pd = tdata; pk = tkeep; pl = tlast;
      prev_last_hs = tvalid && tready && tlast;
    end
  end

  task automatic start_run(input int len, input int num, input int gap, input bit mode);
    @(posedge clk); #1;
    cfg_pkt_len = 16'(len); cfg_pkt_num = 32'(num); cfg_gap = 8'(gap); cfg_mode = mode;
    cfg_start = 1'b1;
    low_cnt = 0; hs_cnt = 0;
    cap_data.delete(); cap_keep.delete();
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget) begin
      @(posedge clk); #2;
      if (done) break;
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done, required done within %0d cycles", name, budget);
    end else begin
      chk({name, "_done_after_tlast"}, 64'(prev_last_hs), 64'd1);
    end
    chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n;
    n = 0;
    while (hs_cnt < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (hs_cnt < target) begin
      checks++; errors++;
      $display("FAIL wait_hs: got %0d beats, required %0d", hs_cnt, target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cnt", sent, 64'd0);
    rst = 1'b0;

    // Simultaneous start and stop: stop wins
    @(posedge clk); #1;
    cfg_pkt_len = 16'd8; cfg_pkt_num = 32'd1; cfg_start = 1'b1; cfg_stop = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_stop = 1'b0;
    @(posedge clk); #1;
    chk("start_stop_busy", 64'(busy), 64'd0);

    // 1: len 20, two packets back to back
    push_exp(20, 2, 1'b0);
    start_run(20, 2, 0, 1'b0);
    wait_done(200, "t1");
    chk("t1_cnt", sent, 64'd2);
    chk("t1_beats", 64'(cap_data.size()), 64'd6);
    chk("t1_nobubble", 64'(low_cnt), 64'd0);
    chk("t1_last1_data", cap_data[2], 64'h0000000000000002);
    chk("t1_last1_keep", 64'(cap_keep[2]), 64'h0F);
    chk("t1_beat4_data", cap_data[4], 64'h0000000400000004);
    chk("t1_last2_data", cap_data[5], 64'h0000000000000005);
    @(posedge clk); #2;
    chk("t1_done_pulse", 64'(done), 64'd0);
    chk("t1_cnt_held", sent, 64'd2);

    // 2: exact multiple and zero length
    push_exp(16, 1, 1'b0);
    start_run(16, 1, 0, 1'b0);
    wait_done(200, "t2a");
    chk("t2a_beats", 64'(cap_keep.size()), 64'd2);
    chk("t2a_keep", 64'(cap_keep[1]), 64'hFF);
    push_exp(0, 1, 1'b0);
    start_run(0, 1, 0, 1'b0);
    wait_done(200, "t2b");
    chk("t2b_beats", 64'(cap_keep.size()), 64'd1);
    chk("t2b_keep", 64'(cap_keep[0]), 64'h01);

    // 3: random backpressure
    rnd_ready = 1'b1;
    push_exp(100, 4, 1'b0);
    start_run(100, 4, 0, 1'b0);
    wait_done(2000, "t3");
    chk("t3_cnt", sent, 64'd4);
    chk("t3_beats", 64'(cap_data.size()), 64'd52);
    rnd_ready = 1'b0;

    // 4: unlimited, gap 3, stop during packet 2
    push_exp(20, 2, 1'b0);
    start_run(20, 0, 3, 1'b0);
    wait_hs(4, 200);
    cfg_stop = 1'b1;
    @(posedge clk); #1;
    cfg_stop = 1'b0;
    wait_done(200, "t4");
    chk("t4_cnt", sent, 64'd2);
    chk("t4_gap_cycles", 64'(low_cnt), 64'd3);

    // 5: LFSR payload
    push_exp(8, 2, 1'b1);
    start_run(8, 2, 0, 1'b1);
    wait_done(200, "t5");
    chk("t5_beat0", cap_data[0], 64'hFFFFFFFF_FFFFFFFF);
    chk("t5_beat1", cap_data[1], 64'hFFDFFFFC_FFDFFFFC);

    // 6: asynchronous reset mid-packet, then restart
    push_exp(100, 1, 1'b0);
    start_run(100, 1, 0, 1'b0);
    wait_hs(3, 200);
    chk("t6_pre_valid", 64'(tvalid), 64'd1);
    sb_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(tvalid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_cnt", sent, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    sb_en = 1'b1;
    push_exp(8, 2, 1'b0);
    start_run(8, 2, 0, 1'b0);
    wait_done(200, "t6");
    chk("t6_beat0", cap_data[0], 64'h0);
    chk("t6_beat1", cap_data[1], 64'h0000000100000001);
    chk("t6_cnt", sent, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_traffic_gen.md
Name: axis_traffic_gen

Overview:
- AXI4-Stream packet generator that drives the TX side of the stream under test, and the tx_mon_* taps of the downstream stream monitor.
- Produces a configurable number of fixed-length packets with a deterministic payload (beat counter or LFSR), so the loopback compare and throughput stats in the monitor have known stimulus.
- Honours backpressure, supports inter-packet gaps, and stops gracefully on packet boundaries.

Parameters:
- DWIDTH, 64, tdata width in bits; multiple of 32, at least 32.
- LEN_WIDTH, 16, width of the packet-length field, in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- cfg_start  in  1  one-cycle start pulse; latches all cfg_* inputs.
- cfg_stop  in  1  one-cycle stop request.
- cfg_pkt_len  in  LEN_WIDTH  packet length in bytes; 0 is treated as 1.
- cfg_pkt_num  in  32  packets to send; 0 means unlimited.
- cfg_gap  in  8  idle cycles after each packet.
- cfg_mode  in  1  payload mode: 0 = beat counter, 1 = LFSR.
- m_axis_tdata  out  DWIDTH  payload.
- m_axis_tvalid  out  1  valid.
- m_axis_tready  in  1  ready.
- m_axis_tkeep  out  DWIDTH/8  byte enables.
- m_axis_tlast  out  1  last beat of packet.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- sent_pkt_cnt  out  64  count of completed packets in the current run.

Behaviour:
- Reset values: every output is 0, state is IDLE. An asynchronous reset mid-packet drops tvalid immediately; no recovery of the partial packet.
- Terms used below:
  - BYTES = DWIDTH/8.
  - L = latched length, with 0 forced to 1.
  - Beats per packet = ceil(L/BYTES).
  - Handshake (hs) = tvalid & tready.
- State machine, states IDLE, SEND, GAP:
  - IDLE: on cfg_start & ~cfg_stop, latch config, clear sent_pkt_cnt, counter and beat index, seed the LFSR, and go to SEND. tvalid rises the cycle after the start pulse.
  - SEND: tvalid = 1. On hs, advance the beat index and payload. On hs & tlast:
    - increment sent_pkt_cnt;
    - if the stop flag is set, or cfg_pkt_num != 0 and the count reaches cfg_pkt_num, go to IDLE and pulse done;
    - else if gap = 0, start the next packet in the next cycle (back-to-back, no bubble);
    - else go to GAP.
  - GAP: tvalid = 0 for exactly cfg_gap cycles, then SEND. A stop received during GAP goes to IDLE with done at the end of the gap.
- cfg_start while busy is ignored. cfg_stop in IDLE is ignored. Simultaneous start and stop in IDLE: stop wins, stay in IDLE.
- cfg_stop while busy sets a sticky stop flag. The current packet always completes; packets are never truncated.
- AXI stability: while tvalid & ~tready, tdata, tkeep and tlast are held constant.
- tlast is asserted on beat index ceil(L/BYTES)-1.
- tkeep:
  - all ones on non-last beats;
  - on the last beat, the low (L mod BYTES) bits are set, or all ones if L mod BYTES = 0.
  - tdata bytes with tkeep = 0 are driven to 0.
- Payload, mode 0: a 32-bit beat counter runs across the whole run and is cleared at start. tdata = counter replicated DWIDTH/32 times. The counter increments on every hs, so it continues across packet boundaries.
- Payload, mode 1: a 32-bit Galois right-shift LFSR, mask 0x80200003, seed 0xFFFFFFFF.
  - next = (s>>1) ^ (s[0] ? mask : 0).
  - tdata = state replicated; the LFSR advances on every hs.
- sent_pkt_cnt is held after done until the next start. It wraps modulo 2^64.
- Beat counter and beat index wrap naturally; the beat index is LEN_WIDTH wide.

Decomposition:
- Package axis_traffic_gen_pkg holds:
  - the state enum {IDLE, SEND, GAP};
  - LFSR_MASK = 32'h80200003 and LFSR_SEED = 32'hFFFFFFFF;
  - a function lfsr_next(logic [31:0]).
- One sub-module, axis_traffic_gen_keep: combinational last-beat tkeep and beat-count calculation from L and BYTES.

Test Plan:
1. DWIDTH=64, len=20, num=2, gap=0, mode 0, tready=1 -> 6 contiguous beats; tdata words 0..5 replicated; tlast on beats 3 and 6; last-beat tkeep=0x0F with upper 4 bytes 0; done pulse; sent_pkt_cnt=2.
2. len=16 and len=0 -> 2 beats with last tkeep=0xFF, and 1 beat with tkeep=0x01, respectively.
3. len=100, num=4, random tready at 50% -> outputs stable during every stall; payload sequence identical to the tready=1 run; sent_pkt_cnt=4.
4. num=0, gap=3, cfg_stop pulsed on beat 2 of packet 2 -> packet 2 completes fully; exactly 3 tvalid-low cycles between packets 1 and 2; done the cycle after packet 2's tlast hs.
5. mode 1, len=8, num=2 -> beat 0 tdata=0xFFFFFFFF_FFFFFFFF, beat 1 tdata=0xFFDFFFFC_FFDFFFFC.
6. rst asserted asynchronously mid-packet with tvalid=1 -> tvalid drops before the next clk edge; busy=0, sent_pkt_cnt=0; a fresh start restarts the counter at 0.
